activation_pwl_unit: RTL

//  Pipelined, parametrised activation unit for the TPU output path. Replaces the fixed sparse

---
 rtl/activation_pkg.sv | 52 +++++
 rtl/activation_pwl_unit_lut.sv | 65 ++++++
 rtl/activation_pwl_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - mode encodings, default PWL tables and saturation helpers
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_SIGMOID = 2'b00,
        ACT_TANH    = 2'b01,
        ACT_RELU    = 2'b10,
        ACT_IDENT   = 2'b11
    } act_mode_e;

    // Default tables are characterised for DATA_WIDTH=8, SEG_BITS=4: segment i
    // starts at x = (i-8)/2. Entry 0 sits in the least significant byte.
    localparam logic [127:0] SIG_BASE_DEF  = {8'hF8, 8'hF3, 8'hEC, 8'hE1, 8'hD0, 8'hBA, 8'h9F, 8'h80,
                                              8'h60, 8'h45, 8'h2F, 8'h1E, 8'h13, 8'h0C, 8'h07, 8'h05};
    localparam logic [127:0] SIG_SLOPE_DEF = {8'h00, 8'h05, 8'h07, 8'h0B, 8'h11, 8'h16, 8'h1B, 8'h1F,
                                              8'h20, 8'h1B, 8'h16, 8'h11, 8'h0B, 8'h07, 8'h05, 8'h02};
    localparam logic [127:0] TANH_BASE_DEF = {8'h7F, 8'h7E, 8'h7D, 8'h7A, 8'h73, 8'h61, 8'h3B, 8'h00,
                                              8'hC5, 8'h9F, 8'h8D, 8'h86, 8'h83, 8'h82, 8'h81, 8'h81};
    localparam logic [127:0] TANH_SLOPE_DEF = {8'h00, 8'h01, 8'h01, 8'h03, 8'h07, 8'h12, 8'h26, 8'h3B,
                                               8'h3B, 8'h26, 8'h12, 8'h07, 8'h03, 8'h01, 8'h01, 8'h00};

    function automatic logic [7:0] def_base(input logic tbl, input int idx);
        if (idx < 0 || idx > 15) return 8'h00;
        return tbl ? TANH_BASE_DEF[idx*8 +: 8] : SIG_BASE_DEF[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] def_slope(input logic tbl, input int idx);
        if (idx < 0 || idx > 15) return 8'h00;
        return tbl ? TANH_SLOPE_DEF[idx*8 +: 8] : SIG_SLOPE_DEF[idx*8 +: 8];
    endfunction

    // Clamp to [0, 2^dw-1].
    function automatic logic [31:0] sat_unsigned(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< dw) - 32'sd1;
        if (v < 0) return 32'd0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Clamp to [-2^(dw-1), 2^(dw-1)-1].
    function automatic logic [31:0] sat_signed(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/activation_pwl_unit_lut.sv
// rtl/activation_pwl_unit_lut.sv - two run-time loadable base/slope tables with registered read
// Ports: clk/rst; wr_* synchronous table write; rd_en/rd_table/rd_addr read request,
// rd_base/rd_slope registered read data (held while rd_en is low).
module pwl_lut_bank
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SEG_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_table,
    input  logic [SEG_BITS-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_base,
    input  logic [DATA_WIDTH-1:0] wr_slope,
    input  logic                  rd_en,
    input  logic                  rd_table,
    input  logic [SEG_BITS-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0] rd_base,
    output logic [DATA_WIDTH-1:0] rd_slope
);
    localparam int DEPTH = 1 << SEG_BITS;

    logic [DATA_WIDTH-1:0] base_q  [2][DEPTH];
    logic [DATA_WIDTH-1:0] slope_q [2][DEPTH];
    logic [DATA_WIDTH-1:0] base_d  [2][DEPTH];
    logic [DATA_WIDTH-1:0] slope_d [2][DEPTH];
    logic [DATA_WIDTH-1:0] rd_base_q, rd_base_d, rd_slope_q, rd_slope_d;

    always_comb begin
        base_d  = base_q;
        slope_d = slope_q;
        if (wr_en) begin
            base_d[wr_table][wr_addr]  = wr_base;
            slope_d[wr_table][wr_addr] = wr_slope;
        end
        // Reads use the pre-write contents, so a same-cycle write is seen one cycle later.
        rd_base_d  = rd_en ? base_q[rd_table][rd_addr]  : rd_base_q;
        rd_slope_d = rd_en ? slope_q[rd_table][rd_addr] : rd_slope_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 2; t++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    // Sigmoid bases are unsigned; tanh bases and all slopes are signed.
                    base_q[t][i]  <= (t == 1) ? DATA_WIDTH'($signed(def_base(1'b1, i)))
                                              : DATA_WIDTH'(def_base(1'b0, i));
                    slope_q[t][i] <= DATA_WIDTH'($signed(def_slope(t == 1, i)));
                end
            end
            rd_base_q  <= '0;
            rd_slope_q <= '0;
        end else begin
            base_q     <= base_d;
            slope_q    <= slope_d;
            rd_base_q  <= rd_base_d;
            rd_slope_q <= rd_slope_d;
        end
    end

    assign rd_base  = rd_base_q;
    assign rd_slope = rd_slope_q;
endmodule

// File: rtl/activation_pwl_unit.sv
// rtl/activation_pwl_unit.sv - 3-stage piecewise-linear sigmoid/tanh/relu/identity unit
// Ports: clk, rst; in_valid/in_ready/in_data/in_mode input stream; out_valid/out_ready/out_data
// result stream; cfg_we/cfg_table/cfg_addr/cfg_base/cfg_slope table write port.
module activation_pwl_unit
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 5,
    parameter int SEG_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  cfg_we,
    input  logic                  cfg_table,
    input  logic [SEG_BITS-1:0]   cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_base,
    input  logic [DATA_WIDTH-1:0] cfg_slope
);
    localparam int IB = DATA_WIDTH - SEG_BITS;   // interpolation bits below the segment index
    localparam int SW = DATA_WIDTH + IB + 2;     // headroom for base + slope*frac
    localparam int UNUSED_FRAC = FRAC_BITS;      // input scaling only affects table contents

    logic                  adv;
    logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] s1_x_q, s1_x_d, s2_x_q, s2_x_d, out_data_q, out_data_d;
    act_mode_e             s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
    logic [IB-1:0]         s2_frac_q, s2_frac_d;
    logic [SEG_BITS-1:0]   s1_idx;
    logic [DATA_WIDTH-1:0] rd_base, rd_slope;
    logic signed [SW-1:0]  base_ext, prod, sum;
    logic [DATA_WIDTH-1:0] y;

    // Offset-binary segment index: most-negative input maps to segment 0.
    assign s1_idx = {~s1_x_q[DATA_WIDTH-1], s1_x_q[DATA_WIDTH-2:IB]};

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv & ~cfg_we & ~rst;

    pwl_lut_bank #(.DATA_WIDTH(DATA_WIDTH), .SEG_BITS(SEG_BITS)) u_lut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_we),
        .wr_table (cfg_table),
        .wr_addr  (cfg_addr),
        .wr_base  (cfg_base),
        .wr_slope (cfg_slope),
        .rd_en    (adv),
        .rd_table (s1_mode_q == ACT_TANH),
        .rd_addr  (s1_idx),
        .rd_base  (rd_base),
        .rd_slope (rd_slope)
    );

    always_comb begin
        base_ext = (s2_mode_q == ACT_SIGMOID) ? SW'($unsigned(rd_base)) : SW'($signed(rd_base));
        prod     = SW'($signed(rd_slope)) * SW'($signed({1'b0, s2_frac_q}));
        sum      = base_ext + (prod >>> IB);
        case (s2_mode_q)
            ACT_SIGMOID: y = DATA_WIDTH'(sat_unsigned(32'(sum), DATA_WIDTH));
            ACT_TANH:    y = DATA_WIDTH'(sat_signed(32'(sum), DATA_WIDTH));
            ACT_RELU:    y = s2_x_q[DATA_WIDTH-1] ? '0 : s2_x_q;
            default:     y = s2_x_q;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        s2_x_d      = s2_x_q;
        s2_mode_d   = s2_mode_q;
        s2_frac_d   = s2_frac_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            s1_valid_d  = in_valid & in_ready;
            s1_x_d      = in_data;
            s1_mode_d   = act_mode_e'(in_mode);
            s2_valid_d  = s1_valid_q;
            s2_x_d      = s1_x_q;
            s2_mode_d   = s1_mode_q;
            s2_frac_d   = s1_x_q[IB-1:0];
            out_valid_d = s2_valid_q;
            if (s2_valid_q) out_data_d = y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_mode_q   <= ACT_SIGMOID;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_mode_q   <= ACT_SIGMOID;
            s2_frac_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_x_q      <= s2_x_d;
            s2_mode_q   <= s2_mode_d;
            s2_frac_q   <= s2_frac_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule
